// File: rtl/xoodyak_pkg.sv
// Shared widths, FSM encoding and the Down flip mask for the Xoodyak absorb phase.
package xoodyak_pkg;

    localparam int STATE_W = 384;
    localparam int RATE_W  = 352;
    localparam int IDX_W   = 4;

    // Down inverts bits 24, 1 and 0 on top of the rate XOR.
    localparam logic [STATE_W-1:0] DOWN_MASK = {{(STATE_W-32){1'b0}}, 32'h0100_0003};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PERM = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } absorb_fsm_e;

endpackage

// File: rtl/xoodyak_down.sv
// Combinational Down(): XOR the rate block into the top of the state and
// apply the fixed padding/domain flips. Shared by any phase that absorbs.
module xoodyak_down
    import xoodyak_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [RATE_W-1:0]  i_blk,
    output logic [STATE_W-1:0] o_state
);

    assign o_state = i_state ^ {i_blk, {(STATE_W-RATE_W){1'b0}}} ^ DOWN_MASK;

endmodule

// File: rtl/xoodyak_absorb_ctrl.sv
// Absorb-phase sequencer: alternates permutation runs (external round function)
// with Down() of each offered block. Optional block counter: XOODYAK_ABSORB_BLKCNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// PERM  | one external round per cycle, rnd_idx 0..NROUNDS-1
// WAIT  | blk_ready high, next block absorbed on blk_valid
// DONE  | absorb_complete pulse, absorbed_state valid
module xoodyak_absorb_ctrl
    import xoodyak_pkg::*;
#(
    parameter int NROUNDS = 12
) (
    input  logic               eph1,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_initial,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [RATE_W-1:0]  blk_data,
    input  logic               blk_last,
    output logic [STATE_W-1:0] rnd_state_out,
    output logic [IDX_W-1:0]   rnd_idx,
    input  logic [STATE_W-1:0] rnd_state_in,
    output logic [STATE_W-1:0] absorbed_state,
    output logic               absorb_complete,
    output logic               busy
`ifdef XOODYAK_ABSORB_BLKCNT_EN
    ,
    output logic [15:0]        blk_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROUNDS - 1);

    absorb_fsm_e        r_fsm;
    absorb_fsm_e        w_fsm_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [STATE_W-1:0] r_absorbed;
    logic               w_abs_load;
    logic [STATE_W-1:0] w_down;

    xoodyak_down u_down (
        .i_state (r_state),
        .i_blk   (blk_data),
        .o_state (w_down)
    );

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_abs_load  = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = state_initial;
                    w_cnt_nxt   = '0;
                    w_fsm_nxt   = ST_PERM;
                end
            end
            ST_PERM: begin
                w_state_nxt = rnd_state_in;
                if (r_cnt == LAST_IDX) begin
                    w_cnt_nxt = '0;
                    w_fsm_nxt = ST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (blk_valid) begin
                    w_state_nxt = w_down;
                    w_cnt_nxt   = '0;
                    if (blk_last) begin
                        w_abs_load = 1'b1;
                        w_fsm_nxt  = ST_DONE;
                    end else begin
                        w_fsm_nxt = ST_PERM;
                    end
                end
            end
            ST_DONE: begin
                w_fsm_nxt = ST_IDLE;
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            r_fsm      <= ST_IDLE;
            r_cnt      <= '0;
            r_state    <= '0;
            r_absorbed <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            if (w_abs_load) begin
                r_absorbed <= w_down;
            end
        end
    end

    assign blk_ready       = (r_fsm == ST_WAIT);
    assign absorb_complete = (r_fsm == ST_DONE);
    assign busy            = (r_fsm != ST_IDLE);
    assign rnd_state_out   = r_state;
    assign rnd_idx         = r_cnt;
    assign absorbed_state  = r_absorbed;

`ifdef XOODYAK_ABSORB_BLKCNT_EN
    logic [15:0] r_blk_count;
    logic        w_start_acc;
    logic        w_blk_acc;

    assign w_start_acc = (r_fsm == ST_IDLE) && start;
    assign w_blk_acc   = (r_fsm == ST_WAIT) && blk_valid;

    // Saturating so a very long message never wraps back to a small count.
    always_ff @(posedge eph1) begin
        if (reset) begin
            r_blk_count <= '0;
        end else if (w_start_acc) begin
            r_blk_count <= '0;
        end else if (w_blk_acc && (r_blk_count != 16'hFFFF)) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_xoodyak_absorb_ctrl.sv
// Scoreboard bench for xoodyak_absorb_ctrl: driver pushes expected absorbed
// states, a negedge monitor pops them on every absorb_complete pulse.
module tb_xoodyak_absorb_ctrl #(
    parameter int NROUNDS = 12
);

    logic         eph1;
    logic         reset;
    logic         start;
    logic [383:0] state_initial;
    logic         blk_valid;
    logic         blk_ready;
    logic [351:0] blk_data;
    logic         blk_last;
    logic [383:0] rnd_state_out;
    logic [3:0]   rnd_idx;
    logic [383:0] rnd_state_in;
    logic [383:0] absorbed_state;
    logic         absorb_complete;
    logic         busy;
`ifdef XOODYAK_ABSORB_BLKCNT_EN
    logic [15:0]  blk_count;
`endif

    logic         model_plus;
    int           total = 0;
    int           bad   = 0;
    logic [383:0] exp_q[$];

    xoodyak_absorb_ctrl #(.NROUNDS(NROUNDS)) dut (
        .eph1            (eph1),
        .reset           (reset),
        .start           (start),
        .state_initial   (state_initial),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_data        (blk_data),
        .blk_last        (blk_last),
        .rnd_state_out   (rnd_state_out),
        .rnd_idx         (rnd_idx),
        .rnd_state_in    (rnd_state_in),
        .absorbed_state  (absorbed_state),
        .absorb_complete (absorb_complete),
        .busy            (busy)
`ifdef XOODYAK_ABSORB_BLKCNT_EN
        ,
        .blk_count       (blk_count)
`endif
    );

    // External round function stand-in: identity or +1 per round.
    always_comb rnd_state_in = model_plus ? rnd_state_out + 384'd1 : rnd_state_out;

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [383:0] ref_down(input logic [383:0] s, input logic [351:0] b);
        return s ^ {b, 32'h0} ^ {352'h0, 32'h0100_0003};
    endfunction

    always @(negedge eph1) begin
        if (absorb_complete) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL complete: unexpected pulse absorbed=%0h want no pulse", absorbed_state);
            end else begin
                chk("absorbed", absorbed_state, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic start_session(input logic [383:0] init);
        start         = 1'b1;
        state_initial = init;
        tick();
        start         = 1'b0;
    endtask

    // Called in session cycle first_n (cycle 1 = first after the start edge).
    task automatic wait_ready(input string tag, input int first_n);
        int n;
        n = first_n;
        while (!blk_ready && n <= 100) begin
            if (n <= NROUNDS) chk({tag, " idx"}, 384'(rnd_idx), 384'(n - 1));
            chk({tag, " busy"}, 384'(busy), 384'd1);
            tick();
            n++;
        end
        chk({tag, " ready cycle"}, 384'(n), 384'(NROUNDS + 1));
    endtask

    task automatic send_last(input logic [351:0] d);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        chk("done ready low", 384'(blk_ready), 384'd0);
        chk("complete high", 384'(absorb_complete), 384'd1);
        tick();
        chk("complete one cycle", 384'(absorb_complete), 384'd0);
        chk("idle busy", 384'(busy), 384'd0);
    endtask

    initial begin
        logic [383:0] init_b, init_c, init_d, exp_s;
        logic [351:0] b0, b1, b2, ones;
        int           target;
        int           guard;

        init_b = {96'h0123_4567_89AB_CDEF_0011_2233, 96'h4455_6677_8899_AABB_CCDD_EEFF,
                  96'hDEAD_BEEF_CAFE_F00D_1357_9BDF, 96'h2468_ACE0_F0E1_D2C3_B4A5_9687};
        init_c = ~init_b;
        init_d = {12{32'h5A5A_0F0F}};
        b0     = {11{32'h1111_2222}};
        b1     = {11{32'hA5A5_5A5A}};
        b2     = {11{32'h0F0F_F0F0}};
        ones   = {352{1'b1}};

        // Reset asserted together with start and blk_valid: reset wins.
        reset         = 1'b1;
        start         = 1'b1;
        blk_valid     = 1'b1;
        blk_last      = 1'b0;
        blk_data      = '0;
        state_initial = init_b;
        model_plus    = 1'b0;
        repeat (3) tick();
        chk("rst busy", 384'(busy), 384'd0);
        chk("rst ready", 384'(blk_ready), 384'd0);
        chk("rst complete", 384'(absorb_complete), 384'd0);
        chk("rst absorbed", absorbed_state, 384'd0);
        chk("rst state", rnd_state_out, 384'd0);
        chk("rst idx", 384'(rnd_idx), 384'd0);
`ifdef XOODYAK_ABSORB_BLKCNT_EN
        chk("rst blk_count", 384'(blk_count), 384'd0);
`endif
        start     = 1'b0;
        blk_valid = 1'b0;
        reset     = 1'b0;
        tick();

        // A: zero state, identity rounds, one all-ones last block.
        start_session(384'd0);
        wait_ready("A", 1);
        exp_q.push_back({{352{1'b1}}, 32'h0100_0003});
        send_last(ones);

        // B: +1 rounds, three blocks, blk_valid held high from before start.
        model_plus = 1'b1;
        blk_valid  = 1'b1;
        blk_data   = b0;
        blk_last   = 1'b0;
        exp_s = ref_down(init_b + 384'(NROUNDS), b0);
        exp_s = ref_down(exp_s + 384'(NROUNDS), b1);
        exp_s = ref_down(exp_s + 384'(NROUNDS), b2);
        exp_q.push_back(exp_s);
        tick();
        chk("B idle ignores valid", 384'(busy), 384'd0);
        start_session(init_b);
        wait_ready("B1", 1);
        chk("B1 wait state", rnd_state_out, init_b + 384'(NROUNDS));
        tick();
        chk("B1 one accept", 384'(blk_ready), 384'd0);
        blk_data = b1;
        wait_ready("B2", 1);
        tick();
        chk("B2 one accept", 384'(blk_ready), 384'd0);
        blk_data = b2;
        blk_last = 1'b1;
        wait_ready("B3", 1);
        tick();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        chk("B complete high", 384'(absorb_complete), 384'd1);
`ifdef XOODYAK_ABSORB_BLKCNT_EN
        chk("B blk_count", 384'(blk_count), 384'd3);
`endif
        tick();
        chk("B complete one cycle", 384'(absorb_complete), 384'd0);
        chk("B absorbed holds", absorbed_state, exp_s);

        // C: start re-pulsed in PERM and in WAIT must be ignored.
        start_session(init_c);
        start         = 1'b1;
        state_initial = init_b;
        tick();
        start = 1'b0;
        wait_ready("C", 2);
        start         = 1'b1;
        state_initial = init_b;
        tick();
        start = 1'b0;
        chk("C wait ready", 384'(blk_ready), 384'd1);
        chk("C wait state", rnd_state_out, init_c + 384'(NROUNDS));
        chk("C wait idx", 384'(rnd_idx), 384'd0);
        exp_q.push_back(ref_down(init_c + 384'(NROUNDS), b1));
        send_last(b1);

        // D: reset in the middle of a permutation run, then a clean session.
        target = (NROUNDS > 5) ? 5 : NROUNDS - 1;
        start_session(init_d);
        guard = 0;
        while (32'(rnd_idx) != target && guard < 100) begin
            tick();
            guard++;
        end
        chk("D reached round", 384'(rnd_idx), 384'(target));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("D busy", 384'(busy), 384'd0);
        chk("D absorbed", absorbed_state, 384'd0);
        chk("D state", rnd_state_out, 384'd0);
        chk("D ready", 384'(blk_ready), 384'd0);
`ifdef XOODYAK_ABSORB_BLKCNT_EN
        chk("D blk_count", 384'(blk_count), 384'd0);
`endif
        repeat (3) tick();
        chk("D stays idle", 384'(busy), 384'd0);
        model_plus = 1'b0;
        start_session(init_d);
        wait_ready("E", 1);
        exp_q.push_back(ref_down(init_d, b2));
        send_last(b2);
        repeat (2) tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending: got %0d completions outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
